// File: rtl/keypad_debouncer_pkg.sv
// Shared definitions for the keypad debouncer and the scanner that drives it.
package keypad_debouncer_pkg;

   typedef enum logic {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } deb_state_e;

   // 5 ms at 48 MHz.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

endpackage

// File: rtl/keypad_debouncer_sync_2ff.sv
// Two-flop synchroniser for a WIDTH-bit vector of asynchronous key inputs.
module keypad_debouncer_sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig_async,
   output logic [WIDTH-1:0] sig_sync
);

   logic [WIDTH-1:0] s1_d, s1_q;
   logic [WIDTH-1:0] s2_d, s2_q;

   always_comb begin
      s1_d = sig_async;
      s2_d = s1_q;
   end

   // NOTE: flops use non-blocking assignments so every register samples
   // the pre-edge value of its source, giving a true two-stage pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign sig_sync = s2_q;

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces a qualified key vector: the output follows only after the value
// has held constant for DEBOUNCE_CYCLES consecutive clock cycles.
module keypad_debouncer
   import keypad_debouncer_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig_in,
   input  logic             key_pressed,
   output logic [WIDTH-1:0] sig_out
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] cand;
   logic [CW-1:0]    cnt_inc;

   deb_state_e       state_d, state_q;
   logic [WIDTH-1:0] held_d, held_q;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic [WIDTH-1:0] sig_out_d, sig_out_q;

   keypad_debouncer_sync_2ff #(.WIDTH(WIDTH)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .sig_async (sig_in),
      .sig_sync  (s2)
   );

   // key_pressed is already synchronous to clk, so it gates s2 directly.
   assign cand    = key_pressed ? s2 : '0;
   assign cnt_inc = cnt_q + CNT_ONE;

   always_comb begin
      // NOTE: every output of this block gets a default first; without it any
      // path that skips an assignment would infer a latch.
      state_d   = state_q;
      held_d    = held_q;
      cnt_d     = cnt_q;
      sig_out_d = sig_out_q;

      case (state_q)
         STABLE: begin
            if (cand == sig_out_q) begin
               cnt_d = '0;
            end else if (DEBOUNCE_CYCLES == 1) begin
               // A single-cycle window accepts the first sighting outright.
               held_d    = cand;
               sig_out_d = cand;
               cnt_d     = '0;
            end else begin
               held_d  = cand;
               cnt_d   = CNT_ONE;
               state_d = SETTLING;
            end
         end

         SETTLING: begin
            if (cand == held_q) begin
               if (cnt_inc == CNT_MAX) begin
                  sig_out_d = held_q;
                  cnt_d     = '0;
                  state_d   = STABLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (cand == sig_out_q) begin
               // Bounced back to the accepted value: abandon the candidate.
               cnt_d   = '0;
               state_d = STABLE;
            end else begin
               held_d = cand;
               cnt_d  = CNT_ONE;
            end
         end

         default: state_d = STABLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= STABLE;
         held_q    <= '0;
         cnt_q     <= '0;
         sig_out_q <= '0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         cnt_q     <= cnt_d;
         sig_out_q <= sig_out_d;
      end
   end

   assign sig_out = sig_out_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer with DEBOUNCE_CYCLES = 4.
module tb_keypad_debouncer;

   localparam int WIDTH = 4;
   localparam int DEB   = 4;
   // sig_in change -> sig_out change, counted from the drive cycle.
   localparam int LAT_IN = DEB + 2;
   // key_pressed change -> sig_out change (no synchroniser in that path).
   localparam int LAT_KP = DEB;

   typedef struct {
      logic [WIDTH-1:0] val;
      int               cyc;
      string            name;
   } exp_t;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] sig_in;
   logic             key_pressed;
   logic [WIDTH-1:0] sig_out;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 0;
   logic [WIDTH-1:0] prev;
   exp_t sb[$];

   keypad_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk         (clk),
      .reset       (reset),
      .sig_in      (sig_in),
      .key_pressed (key_pressed),
      .sig_out     (sig_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] val, input int lat, input string name);
      exp_t e;
      e.val  = val;
      e.cyc  = cyc + lat;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, sb.size(), 0);
   endtask

   // Monitor: every change on sig_out must match the oldest pending expectation.
   always @(negedge clk) begin
      if (mon_en && sig_out !== prev) begin
         if (sb.size() == 0) begin
            check("unexpected_change", int'(sig_out), int'(prev));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_val"}, int'(sig_out), int'(e.val));
            check({e.name, "_cyc"}, cyc, e.cyc);
         end
         prev = sig_out;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] walk [4];
      walk[0] = 4'b0001;
      walk[1] = 4'b0010;
      walk[2] = 4'b0100;
      walk[3] = 4'b1000;

      reset       = 1'b0;
      sig_in      = 4'b1111;
      key_pressed = 1'b1;

      // Reset held for two edges with all keys asserted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out", int'(sig_out), 0);
      prev   = sig_out;
      mon_en = 1'b1;
      reset  = 1'b1;
      push(4'b1111, LAT_IN, "reset_release");
      idle(10);
      drain("reset_release");

      // Clean walk through one-hot values.
      foreach (walk[i]) begin
         sig_in = walk[i];
         push(walk[i], LAT_IN, "walk");
         idle(10);
      end
      drain("walk");

      // Release to zero, then bounce between 0000 and 0100.
      sig_in = 4'b0000;
      push(4'b0000, LAT_IN, "release");
      idle(10);
      for (int i = 0; i < 7; i++) begin
         sig_in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
         if (i == 6) push(4'b0100, LAT_IN, "bounce");
         idle(1);
      end
      idle(10);
      drain("bounce");

      // Two-cycle glitch on a stable 0010 must not propagate.
      sig_in = 4'b0010;
      push(4'b0010, LAT_IN, "glitch_setup");
      idle(10);
      sig_in = 4'b1000;
      idle(2);
      sig_in = 4'b0010;
      idle(12);
      check("glitch_hold", int'(sig_out), int'(4'b0010));
      drain("glitch");

      // Qualifier drop and restore with sig_in unchanged.
      sig_in = 4'b0001;
      push(4'b0001, LAT_IN, "qual_setup");
      idle(10);
      key_pressed = 1'b0;
      push(4'b0000, LAT_KP, "qual_drop");
      idle(8);
      key_pressed = 1'b1;
      push(4'b0001, LAT_KP, "qual_raise");
      idle(8);
      drain("qual");

      // Reset while settling toward 1000 discards it; full latency after release.
      sig_in = 4'b1000;
      idle(3);
      reset = 1'b0;
      push(4'b0000, 1, "mid_reset");
      idle(1);
      check("mid_reset_out", int'(sig_out), 0);
      reset = 1'b1;
      push(4'b1000, LAT_IN, "post_reset");
      idle(10);
      drain("post_reset");
      check("final_out", int'(sig_out), int'(4'b1000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
